// File: rtl/p_shfrot_ctrl_pkg.sv
// Shared encodings for the packed shift/rotate issue stage: pack-width codes,
// operation codes, output-buffer FSM states and the pack-width decoder.
package p_shfrot_ctrl_pkg;

  localparam logic [2:0] PW_32          = 3'd0;
  localparam logic [2:0] PW_16          = 3'd1;
  localparam logic [2:0] PW_8           = 3'd2;
  localparam logic [2:0] PW_4           = 3'd3;
  localparam logic [2:0] PW_2           = 3'd4;
  localparam logic [2:0] PW_ILLEGAL_MIN = 3'd5;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_ROL = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  // ST_SKID is only reachable when the skid register is built in.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // One-hot pack width for the barrel; illegal codes give all zeros.
  function automatic logic [4:0] pw_onehot(input logic [2:0] code);
    logic [4:0] oh;
    oh = '0;
    for (int i = 0; i < 5; i++) begin
      oh[i] = (code == 3'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/p_shfrot.sv
// Combinational packed shift/rotate barrel. The 32-bit operand is split into
// elements of 32/16/8/4/2 bits selected by the one-hot pw. Shift amounts are
// not masked: shifts of at least the element width give 0, rotates wrap
// modulo the element width.
module p_shfrot (
  input  logic [31:0] crs1,
  input  logic [4:0]  shamt,
  input  logic [4:0]  pw,
  input  logic        shift,
  input  logic        rotate,
  input  logic        left,
  input  logic        right,
  output logic [31:0] result
);

  logic [5:0] width;
  logic [4:0] mask;
  logic [4:0] pos;
  logic [4:0] base;

  // Element width from the one-hot pack width; no bit set falls back to 32.
  always_comb begin
    width = 6'd32;
    unique case (1'b1)
      pw[0]:   width = 6'd32;
      pw[1]:   width = 6'd16;
      pw[2]:   width = 6'd8;
      pw[3]:   width = 6'd4;
      pw[4]:   width = 6'd2;
      default: width = 6'd32;
    endcase
  end

  assign mask = 5'(width - 6'd1);

  // Per result bit: position inside its element and the source bit it takes.
  always_comb begin
    result = '0;
    pos    = '0;
    base   = '0;
    for (int i = 0; i < 32; i++) begin
      pos  = 5'(i) & mask;
      base = 5'(i) & ~mask;
      if (rotate && left) begin
        result[i] = crs1[base | ((pos - shamt) & mask)];
      end else if (rotate && right) begin
        result[i] = crs1[base | ((pos + shamt) & mask)];
      end else if (shift && left) begin
        if (shamt <= pos) result[i] = crs1[base | (pos - shamt)];
      end else if (shift && right) begin
        if (({1'b0, pos} + {1'b0, shamt}) < width) result[i] = crs1[base | (pos + shamt)];
      end
    end
  end

endmodule

// File: rtl/p_shfrot_ctrl.sv
// Issue/control stage in front of the packed shift/rotate barrel: decodes the
// instruction, drives p_shfrot and registers the result into a one-entry output
// buffer with backpressure. Illegal pack widths are returned as a trap with a
// zero result. Define P_SHFROT_CTRL_SKID_EN to add a skid register, which makes
// in_ready a registered signal with no path from out_ready.
//
// Handshake: a transfer happens on an edge where valid and ready are both high;
// the sender holds its payload until then. An input transfer is additionally
// suppressed when flush is high.
module p_shfrot_ctrl
  import p_shfrot_ctrl_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_crs1,
  input  logic [31:0] in_crs2,
  input  logic [4:0]  in_imm,
  input  logic        in_use_imm,
  input  logic [2:0]  in_pw,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_trap
);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  pw;
  logic [4:0]  shamt;
  logic [31:0] barrel_result;
  logic        trap;
  logic [31:0] cap_result;
  logic        accept;
  logic        load_out;
  logic        unused_crs2;

  // Instruction decode feeding the barrel.
  assign pw          = pw_onehot(in_pw);
  assign shamt       = in_use_imm ? in_imm : in_crs2[4:0];
  assign trap        = (in_pw >= PW_ILLEGAL_MIN);
  assign cap_result  = trap ? 32'd0 : barrel_result;
  assign unused_crs2 = ^in_crs2[31:5];

  p_shfrot u_barrel (
    .crs1   (in_crs1),
    .shamt  (shamt),
    .pw     (pw),
    .shift  (!in_op[1]),
    .rotate (in_op[1]),
    .left   (!in_op[0]),
    .right  (in_op[0]),
    .result (barrel_result)
  );

  assign accept = in_valid && in_ready && !flush;

`ifdef P_SHFROT_CTRL_SKID_EN
  logic        in_ready_q;
  logic        load_skid;
  logic        drain_skid;
  logic [31:0] skid_result;
  logic [4:0]  skid_rd;
  logic        skid_trap;
`endif

  // Buffer state register.
  always_ff @(posedge g_clk) begin
    if (g_reset) state <= ST_EMPTY;
    else         state <= state_nxt;
  end

  // Next buffer state; flush empties everything.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (accept) state_nxt = ST_FULL;
`ifdef P_SHFROT_CTRL_SKID_EN
        ST_FULL: begin
          if (out_ready) state_nxt = accept ? ST_FULL : ST_EMPTY;
          else if (accept) state_nxt = ST_SKID;
        end
`else
        ST_FULL: if (out_ready && !accept) state_nxt = ST_EMPTY;
`endif
        ST_SKID:  if (out_ready) state_nxt = ST_FULL;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs and buffer load strobes decoded from the state.
  always_comb begin
    out_valid = (state != ST_EMPTY);
    load_out  = accept && ((state == ST_EMPTY) || ((state == ST_FULL) && out_ready));
`ifdef P_SHFROT_CTRL_SKID_EN
    in_ready   = in_ready_q;
    load_skid  = accept && (state == ST_FULL) && !out_ready;
    drain_skid = !flush && (state == ST_SKID) && out_ready;
`else
    in_ready   = !g_reset && ((state == ST_EMPTY) || out_ready);
`endif
  end

  // Output buffer: loads from the barrel, or from the skid entry when draining.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      out_result <= '0;
      out_rd     <= '0;
      out_trap   <= 1'b0;
    end else if (load_out) begin
      out_result <= cap_result;
      out_rd     <= in_rd;
      out_trap   <= trap;
`ifdef P_SHFROT_CTRL_SKID_EN
    end else if (drain_skid) begin
      out_result <= skid_result;
      out_rd     <= skid_rd;
      out_trap   <= skid_trap;
`endif
    end
  end

`ifdef P_SHFROT_CTRL_SKID_EN
  // Skid entry holds the instruction accepted while the output was stalled.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      skid_result <= '0;
      skid_rd     <= '0;
      skid_trap   <= 1'b0;
    end else if (load_skid) begin
      skid_result <= cap_result;
      skid_rd     <= in_rd;
      skid_trap   <= trap;
    end
  end

  // Registered ready: low only while the skid entry is occupied.
  always_ff @(posedge g_clk) begin
    if (g_reset) in_ready_q <= 1'b0;
    else         in_ready_q <= (state_nxt != ST_SKID);
  end
`endif

endmodule

// File: tb/tb_p_shfrot_ctrl.sv
// Bench for p_shfrot_ctrl (default build): directed test-plan steps followed by
// randomized traffic, all checked against an element-wise arithmetic model and
// an expected-output queue.
module tb_p_shfrot_ctrl;

  // Clock and reset
  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        g_reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_crs1;
  logic [31:0] in_crs2;
  logic [4:0]  in_imm;
  logic        in_use_imm;
  logic [2:0]  in_pw;
  logic [1:0]  in_op;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_trap;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {trap, rd, result}
  logic [37:0] exp_q[$];

  p_shfrot_ctrl dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_crs1    (in_crs1),
    .in_crs2    (in_crs2),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_pw      (in_pw),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_trap   (out_trap)
  );

  // Reference: operate on each element as an integer.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [4:0] s,
                                             input logic [2:0] pwc, input logic [1:0] op);
    int          w;
    int          r;
    logic [63:0] m;
    logic [63:0] e;
    logic [63:0] v;
    logic [63:0] acc;
    w   = 32 >> pwc;
    m   = (64'd1 << w) - 64'd1;
    acc = '0;
    for (int k = 0; k < 32 / w; k++) begin
      e = ({32'd0, a} >> (k * w)) & m;
      r = int'(s) % w;
      case (op)
        2'd0:    v = (int'(s) >= w) ? 64'd0 : ((e << s) & m);
        2'd1:    v = (int'(s) >= w) ? 64'd0 : (e >> s);
        2'd2:    v = ((e << r) | (e >> (w - r))) & m;
        default: v = ((e >> r) | (e << (w - r))) & m;
      endcase
      acc = acc | (v << (k * w));
    end
    return acc[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver
  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] imm, input logic ui, input logic [2:0] pwc,
                        input logic [1:0] op, input logic [4:0] rd, input logic ordy,
                        input logic fl);
    in_valid   = v;
    in_crs1    = a;
    in_crs2    = b;
    in_imm     = imm;
    in_use_imm = ui;
    in_pw      = pwc;
    in_op      = op;
    in_rd      = rd;
    out_ready  = ordy;
    flush      = fl;
  endtask

  // One cycle: check outputs against the scoreboard, then advance the model.
  task automatic step();
    logic        exp_ready;
    logic [37:0] head;
    logic [37:0] item;
    logic [4:0]  s;
    #1;
    exp_ready = !g_reset && (exp_q.size() == 0 || out_ready);
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_result", {32'd0, out_result}, {32'd0, head[31:0]});
      check("out_rd", {59'd0, out_rd}, {59'd0, head[36:32]});
      check("out_trap", {63'd0, out_trap}, {63'd0, head[37]});
    end
    s = in_use_imm ? in_imm : in_crs2[4:0];
    if (in_pw >= 3'd5) item = {1'b1, in_rd, 32'd0};
    else               item = {1'b0, in_rd, ref_result(in_crs1, s, in_pw, in_op)};
    @(posedge g_clk);
    if (g_reset || flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) exp_q.push_back(item);
    end
    @(negedge g_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    g_reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    step();
    check("rst_result", {32'd0, out_result}, 64'd0);
    check("rst_rd", {59'd0, out_rd}, 64'd0);
    check("rst_trap", {63'd0, out_trap}, 64'd0);
    g_reset = 1'b0;

    // ROL, pw=32, imm=8
    set_in(1, 32'h12345678, 0, 5'd8, 1, 3'd0, 2'd2, 5'd3, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("rol32", {32'd0, out_result}, 64'h34567812);
    check("rol32_trap", {63'd0, out_trap}, 64'd0);
    step();

    // SRL, pw=16, shamt from crs2
    set_in(1, 32'h12345678, 32'h24, 5'd31, 0, 3'd1, 2'd1, 5'd7, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("srl16", {32'd0, out_result}, 64'h01230567);
    step();

    // SLL then ROL, pw=8, back-to-back
    set_in(1, 32'h80808080, 0, 5'd1, 1, 3'd2, 2'd0, 5'd1, 1, 0);
    step();
    set_in(1, 32'h80808080, 0, 5'd1, 1, 3'd2, 2'd2, 5'd2, 1, 0);
    check("sll8", {32'd0, out_result}, 64'h0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("rol8", {32'd0, out_result}, 64'h01010101);
    step();

    // Illegal pack width traps
    set_in(1, 32'hcafef00d, 0, 5'd3, 1, 3'd5, 2'd3, 5'd17, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("trap_flag", {63'd0, out_trap}, 64'd1);
    check("trap_result", {32'd0, out_result}, 64'd0);
    check("trap_rd", {59'd0, out_rd}, 64'd17);
    step();

    // Backpressure: three stalled cycles with a waiting instruction
    set_in(1, 32'hdeadbeef, 0, 5'd4, 1, 3'd3, 2'd3, 5'd9, 1, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h0f1e2d3c, 0, 5'd2, 1, 3'd4, 2'd2, 5'd10, 0, 0);
      step();
      check("bp_hold", {32'd0, out_result}, {32'd0, ref_result(32'hdeadbeef, 5'd4, 3'd3, 2'd3)});
    end
    set_in(1, 32'h0f1e2d3c, 0, 5'd2, 1, 3'd4, 2'd2, 5'd10, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("bp_next_rd", {59'd0, out_rd}, 64'd10);
    step();

    // Flush in FULL with a new instruction offered
    set_in(1, 32'h11112222, 0, 5'd5, 1, 3'd0, 2'd0, 5'd20, 0, 0);
    step();
    set_in(1, 32'h33334444, 0, 5'd6, 1, 3'd0, 2'd1, 5'd21, 0, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    step();

    // Reset while FULL
    set_in(1, 32'h55aa55aa, 0, 5'd1, 1, 3'd1, 2'd2, 5'd30, 0, 0);
    step();
    g_reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    g_reset = 1'b0;
    check("rst_full_valid", {63'd0, out_valid}, 64'd0);
    check("rst_full_result", {32'd0, out_result}, 64'd0);
    check("rst_full_rd", {59'd0, out_rd}, 64'd0);
    check("rst_full_trap", {63'd0, out_trap}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 19) == 0));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p_shfrot_ctrl.md
# p_shfrot_ctrl

Issue/control stage placed directly upstream of the combinational packed shift/rotate barrel (`p_shfrot`).
- Accepts decoded packed shift/rotate instructions over a valid/ready handshake.
- Decodes the pack-width field into the barrel's one-hot `pw` and selects the shift amount from the immediate or `crs2`.
- Drives the barrel and registers its result into a one-entry output buffer with backpressure.
- Flags illegal pack-width encodings as a trap instead of producing a result.

## Interface
- Parameters: none.
- `g_clk`  in  1  clock; all state updates on rising edge.
- `g_reset`  in  1  reset. Synchronous, active-high.
- `flush`  in  1  discard input capture and buffered result this cycle.
- `in_valid`  in  1  instruction presented.
- `in_ready`  out  1  stage can accept this cycle.
- `in_crs1`  in  32  source operand.
- `in_crs2`  in  32  source register 2; bits [4:0] give the shift amount when `in_use_imm`=0.
- `in_imm`  in  5  immediate shift amount.
- `in_use_imm`  in  1  1: `shamt`=`in_imm`; 0: `shamt`=`in_crs2[4:0]`.
- `in_pw`  in  3  pack width: 0=32, 1=16, 2=8, 3=4, 4=2, 5–7 illegal.
- `in_op`  in  2  operation: 0=shift left, 1=shift right, 2=rotate left, 3=rotate right.
- `in_rd`  in  5  destination tag, passed through unchanged.
- `out_valid`  out  1  result buffered.
- `out_ready`  in  1  consumer accepts.
- `out_result`  out  32  packed shift/rotate result.
- `out_rd`  out  5  tag of `out_result`.
- `out_trap`  out  1  illegal `in_pw`; `out_result` is 0 when set.

## Operation
- Decode:
  - one-hot `pw[i]` = (`in_pw` == i) for i = 0..4.
  - `shift` = !`in_op[1]`; `rotate` = `in_op[1]`.
  - `left` = !`in_op[0]`; `right` = `in_op[0]`.
- The barrel is fed combinationally from the input operands; its result is captured on acceptance.
- Shift amounts at or above the element width are not masked:
  - shifts by at least the element width produce 0;
  - rotates wrap per element, as the barrel defines.
- Illegal `in_pw`: the instruction is accepted, with `out_trap`=1, `out_result`=0 and `out_rd` captured.
- Acceptance = `in_valid` && `in_ready` && !`flush`.
- Output buffer FSM:
  - EMPTY: `out_valid`=0, `in_ready`=1.
    - Acceptance → FULL.
  - FULL: `out_valid`=1, `in_ready`=`out_ready`.
    - `out_ready` with acceptance → FULL, new data loaded.
    - `out_ready` without acceptance → EMPTY.
    - `!out_ready` → FULL, all outputs held stable.
- `flush`: next state EMPTY regardless of other inputs. A concurrent acceptance is dropped; a concurrent output transfer still counts as taken by the consumer.
- Reset: state EMPTY; `out_valid`=0, `out_result`=0, `out_rd`=0, `out_trap`=0. `in_ready`=0 while `g_reset` is high.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- Without the skid buffer, `in_ready` is combinational from `out_ready` (FULL state) and from `g_reset`.
- `out_*` are registered and change only on an edge where the buffer loads, drains or is flushed.
- Reset asserted mid-transfer takes priority over `flush` and handshakes; the buffered result is lost.

## Configuration
- `P_SHFROT_CTRL_SKID_EN` defined:
  - adds a one-entry skid register, giving states EMPTY / FULL / SKID;
  - `in_ready` is registered, = !(state == SKID), with no combinational path from `out_ready`;
  - in FULL with `!out_ready`, an acceptance goes to the skid register and the state becomes SKID;
  - SKID drains to FULL when `out_ready`;
  - `flush` clears both entries;
  - ordering is preserved.
- Not defined: two-state behaviour as above.

## Structure
- Shared package holds:
  - pack-width encoding constants (PW_32…PW_2, PW_ILLEGAL_MIN=5);
  - op encoding constants (OP_SLL, OP_SRL, OP_ROL, OP_ROR);
  - FSM state constants.
- Instantiates exactly one sub-module, `p_shfrot`, with ports `crs1`, `shamt`, `pw`, `shift`, `rotate`, `left`, `right`, `result`.
- Decode logic is inline; no further sub-modules.

## Test plan
- ROL, pw=32, imm=8, crs1=0x12345678 → next cycle `out_result`=0x34567812, `out_trap`=0.
- SRL, pw=16, `in_use_imm`=0, crs2=0x24 (`shamt`=4), crs1=0x12345678 → 0x01230567.
- SLL then ROL, pw=8, imm=1, crs1=0x80808080 → 0x00000000, then 0x01010101 on back-to-back cycles.
- pw=5, any op → accepted, `out_trap`=1, `out_result`=0, `out_rd` matches `in_rd`.
- Backpressure:
  - hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `out_*` stable and no loss;
  - with `P_SHFROT_CTRL_SKID_EN`: one extra instruction is accepted, then `in_ready`=0; both drain in order.
- `flush` in FULL together with new `in_valid` → state EMPTY, `out_valid`=0 next cycle, new instruction not captured.
- `g_reset` high for one cycle in FULL → `out_valid`=0 and all outputs 0.
